kmeans_iter_ctrl: RTL
=====================

# kmeans_iter_ctrl

Sequencer for the k-means clustering engine. It owns the 4096x16 single-port point SRAM and drives it through three phases: load the point stream, run repeated full-memory scan passes for the group/accumulate datapath, and run a centroid-update handshake after each pass. It stops on convergence or an iteration cap. It sits between the input stream, the SRAM macro and the distance/accumulate/divide datapath, and replaces ad-hoc state decoding inside that datapath.

## Interface
- DATA_SIZE, 4096: number of points; one SRAM word per point.
- ADDR_W, 12: SRAM address width; must satisfy 2^ADDR_W >= DATA_SIZE.
- RD_LAT, 2: cycles from address presented to read data valid at the datapath (SRAM read plus output register); legal range 1..4.
- MAX_ITER, 16: maximum scan/update iterations; legal range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a job; honoured only in IDLE.
- abort  in  1  synchronous abort; highest priority in every state except IDLE.
- wr_valid  in  1  a point is present on the SRAM DI bus this cycle (LOAD only).
- upd_ack  in  1  the datapath has finished the centroid update and `converged` is valid.
- converged  in  1  no centroid moved; sampled only with upd_ack in UPDATE.
- mem_addr  out  ADDR_W  SRAM address.
- mem_we_b  out  1  SRAM write enable, active-low.
- acc_clr  out  1  one-cycle pulse that clears the datapath accumulators before each pass.
- scan_valid  out  1  SRAM read data for one point is valid at the datapath.
- scan_last  out  1  qualifies the final scan_valid of a pass.
- upd_req  out  1  request for a centroid update; level signal.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a job completes normally.
- timeout  out  1  valid with done: the job stopped on the iteration cap, not on convergence.
- iter_cnt  out  8  number of completed iterations; holds its value after done until the next start.

## Operation
- States: IDLE, LOAD, SCAN, DRAIN, UPDATE, FIN.
- All registers and outputs reset to 0, except mem_we_b which resets to 1.
- IDLE
  - start=1 -> LOAD; addr counter cleared; iter_cnt cleared; timeout cleared.
- LOAD
  - mem_addr = addr counter.
  - mem_we_b = !wr_valid; this is the only combinational output, decoded from the state register and wr_valid.
  - Each cycle with wr_valid=1: the write occurs and the counter increments. wr_valid=0 stalls the phase with no write.
  - The write at address DATA_SIZE-1 -> SCAN; counter cleared.
- SCAN
  - acc_clr=1 in the first SCAN cycle of every pass.
  - mem_addr = counter; counter increments every cycle, with no stalls.
  - After address DATA_SIZE-1 has been presented -> DRAIN.
- Read pipeline
  - A RD_LAT-deep valid shift register produces scan_valid exactly RD_LAT cycles after each SCAN address.
  - scan_last is carried through the same shift register, tagged on address DATA_SIZE-1.
- DRAIN
  - Lasts RD_LAT cycles, until the shift register is empty; then -> UPDATE.
  - mem_addr holds DATA_SIZE-1.
- UPDATE
  - upd_req=1 until upd_ack is seen; an ack in the first UPDATE cycle is legal.
  - On ack, iter_cnt increments.
  - If converged=1 -> FIN with timeout=0.
  - Else, if the incremented iter_cnt == MAX_ITER -> FIN with timeout=1.
  - Else -> SCAN; counter cleared.
- FIN
  - done=1 for one cycle, then -> IDLE.
- Outside UPDATE, upd_ack and converged are ignored.
- abort in any non-IDLE state -> IDLE next cycle.
  - Shift register flushed; upd_req dropped; done stays 0.
  - iter_cnt keeps its value.
- Reset mid-job: immediate return to IDLE. SRAM contents are not guaranteed to be reloaded; a new start always reloads.
- mem_we_b=1 in every state other than LOAD.

## Timing
- start in cycle t -> LOAD from t+1; the first write can occur at t+1.
- SCAN pass length: DATA_SIZE cycles of SCAN plus RD_LAT cycles of DRAIN.
- The first scan_valid occurs RD_LAT cycles after SCAN entry.
- scan_valid is high for exactly DATA_SIZE consecutive cycles per pass, with no gaps.
- Minimum iteration: DATA_SIZE + RD_LAT + 1 cycles, with upd_ack in the first UPDATE cycle.
- upd_ack in cycle u: the next SCAN, or FIN, starts at u+1; done is high at u+1 when terminating.
- busy falls in the cycle after done.

## Test plan
- DATA_SIZE=8, RD_LAT=2: start, then 8 continuous wr_valid -> writes to addresses 0..7; SCAN entered 9 cycles after start; scan_valid high for 8 cycles starting 2 cycles after SCAN entry; scan_last on the 8th.
- Load stall: wr_valid pattern 1,0,0,1,... -> no write during gaps; addresses stay contiguous 0..7; exactly 8 writes.
- Convergence: ack with converged=0 twice, then converged=1 -> 3 acc_clr pulses; done with iter_cnt=3 and timeout=0.
- Cap: MAX_ITER=3, converged always 0 -> done after the 3rd ack; iter_cnt=3; timeout=1.
- Abort during the 5th scan address -> IDLE next cycle; scan_valid low within 1 cycle; no done; a later start reloads from address 0.
- Async reset mid-DRAIN, plus start pulsed while busy -> all outputs at reset values immediately; the start while busy has no effect; upd_ack pulsed in IDLE has no effect.

Source files
------------

// File: rtl/kmeans_iter_ctrl.sv
// Sequencer for the k-means engine: loads points into the SRAM, runs full-memory
// scan passes with a read-latency-matched valid pipeline, and handshakes centroid updates.
module kmeans_iter_ctrl #(
    parameter int DATA_SIZE = 4096,
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 2,
    parameter int MAX_ITER  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic              upd_ack,
    input  logic              converged,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we_b,
    output logic              acc_clr,
    output logic              scan_valid,
    output logic              scan_last,
    output logic              upd_req,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [7:0]        iter_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SCAN   = 3'd2,
        DRAIN  = 3'd3,
        UPDATE = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DATA_SIZE - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);
    localparam logic [7:0]        ITER_CAP   = 8'(MAX_ITER);

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [2:0]        drain_cnt;
    logic [RD_LAT-1:0] valid_sr;
    logic [RD_LAT-1:0] last_sr;
    logic              kill;
    logic              scan_in;
    logic              scan_last_in;

    assign kill         = abort && (state != IDLE);
    assign scan_in      = (state == SCAN);
    assign scan_last_in = (state == SCAN) && (addr_cnt == LAST_ADDR);

    // The address counter doubles as the SRAM address; it parks on the last
    // address through DRAIN and UPDATE.
    assign mem_addr   = addr_cnt;
    assign mem_we_b   = !((state == LOAD) && wr_valid);
    assign scan_valid = valid_sr[RD_LAT-1];
    assign scan_last  = last_sr[RD_LAT-1];

    // Delay line matching the SRAM read plus output register latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else if (kill) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr <= (valid_sr << 1) | RD_LAT'(scan_in);
            last_sr  <= (last_sr << 1) | RD_LAT'(scan_last_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            drain_cnt <= '0;
            acc_clr   <= 1'b0;
            upd_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            iter_cnt  <= '0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            if (kill) begin
                state   <= IDLE;
                upd_req <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= LOAD;
                            addr_cnt <= '0;
                            iter_cnt <= '0;
                            timeout  <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (wr_valid) begin
                            if (addr_cnt == LAST_ADDR) begin
                                state    <= SCAN;
                                addr_cnt <= '0;
                                acc_clr  <= 1'b1;
                            end else begin
                                addr_cnt <= addr_cnt + 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (addr_cnt == LAST_ADDR) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state   <= UPDATE;
                            upd_req <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 3'd1;
                        end
                    end
                    // Convergence wins over the iteration cap when both apply.
                    UPDATE: begin
                        if (upd_ack) begin
                            upd_req  <= 1'b0;
                            iter_cnt <= iter_cnt + 8'd1;
                            if (converged) begin
                                state   <= FIN;
                                done    <= 1'b1;
                                timeout <= 1'b0;
                            end else if ((iter_cnt + 8'd1) == ITER_CAP) begin
                                state   <= FIN;
                                done    <= 1'b1;
                                timeout <= 1'b1;
                            end else begin
                                state    <= SCAN;
                                addr_cnt <= '0;
                                acc_clr  <= 1'b1;
                            end
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
